// File: rtl/pwm_capture.sv
// PWM input measurement: synchronises pwm_in, times each rise-to-rise period and its high phase,
// and drops 'active' when a required edge fails to arrive within TIMEOUT cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for the synchronised input to read low
// ARM     | waiting for the first rise; the partial period before it is discarded
// HIGH    | input high, counting; a fall latches the high-phase length
// LOW     | input low, counting; a rise publishes period/high_time
module pwm_capture #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 20000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             active,
   output logic             stuck_level
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   logic             sync1_q;
   logic             s_q;
   logic             s_d_q;
   state_t           state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [CNT_W-1:0] hi_lat_q,    hi_lat_d;
   logic [CNT_W-1:0] period_q,    period_d;
   logic [CNT_W-1:0] high_time_q, high_time_d;
   logic             valid_q,     valid_d;
   logic             active_q,    active_d;
   logic             stuck_q,     stuck_d;

   logic rise;
   logic fall;
   logic at_limit;

   assign rise     = s_q & ~s_d_q;
   assign fall     = ~s_q & s_d_q;
   assign at_limit = (cnt_q == TIMEOUT_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         s_q         <= 1'b0;
         s_d_q       <= 1'b0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hi_lat_q    <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         valid_q     <= 1'b0;
         active_q    <= 1'b0;
         stuck_q     <= 1'b0;
      end else begin
         sync1_q     <= pwm_in;
         s_q         <= sync1_q;
         s_d_q       <= s_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_lat_q    <= hi_lat_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         valid_q     <= valid_d;
         active_q    <= active_d;
         stuck_q     <= stuck_d;
      end
   end

   // A required edge arriving on the same cycle as the limit is a normal transition.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_lat_d    = hi_lat_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      valid_d     = 1'b0;
      active_d    = active_q;
      stuck_d     = stuck_q;
      case (state_q)
         ST_IDLE: begin
            if (!s_q) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (rise) begin
               state_d = ST_HIGH;
               cnt_d   = ONE_C;
            end
         end
         ST_HIGH: begin
            cnt_d = cnt_q + ONE_C;
            if (fall) begin
               state_d  = ST_LOW;
               hi_lat_d = cnt_q;
            end else if (at_limit) begin
               state_d  = ST_IDLE;
               active_d = 1'b0;
               stuck_d  = 1'b1;
            end
         end
         ST_LOW: begin
            if (rise) begin
               state_d     = ST_HIGH;
               period_d    = cnt_q;
               high_time_d = hi_lat_q;
               valid_d     = 1'b1;
               active_d    = 1'b1;
               cnt_d       = ONE_C;
            end else begin
               cnt_d = cnt_q + ONE_C;
               if (at_limit) begin
                  state_d  = ST_IDLE;
                  active_d = 1'b0;
                  stuck_d  = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign period      = period_q;
   assign high_time   = high_time_q;
   assign valid       = valid_q;
   assign active      = active_q;
   assign stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: hand-computed periods, high times, timeout instants and reset behaviour.
module tb_pwm_capture;

   localparam int CNT_W = 16;
   localparam int TO    = 6000;

   logic             clk = 1'b0;
   logic             rst;
   logic             pwm_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             active;
   logic             stuck_level;

   int n_cmp = 0;
   int n_bad = 0;
   int q_per[$];
   int q_hi[$];
   int q_act[$];

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .pwm_in      (pwm_in),
      .period      (period),
      .high_time   (high_time),
      .valid       (valid),
      .active      (active),
      .stuck_level (stuck_level)
   );

   always #5 clk = ~clk;

   // strobe recorder, sampled away from the active edge
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         q_per.push_back(int'(period));
         q_hi.push_back(int'(high_time));
         q_act.push_back(int'(active));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wave(input int hi, input int lo, input int n);
      repeat (n) begin
         pwm_in = 1'b1;
         tick(hi);
         pwm_in = 1'b0;
         tick(lo);
      end
   endtask

   task automatic pop_strobe(input string tag, input int per, input int hi);
      check({tag, "_avail"}, 32'(q_per.size() > 0), 32'd1);
      if (q_per.size() > 0) begin
         check({tag, "_period"}, 32'(q_per.pop_front()), 32'(per));
         check({tag, "_high"},   32'(q_hi.pop_front()),  32'(hi));
         check({tag, "_active"}, 32'(q_act.pop_front()), 32'd1);
      end
   endtask

   task automatic check_strobes(input string tag, input int n, input int per, input int hi);
      check({tag, "_count"}, 32'(q_per.size()), 32'(n));
      repeat (n) pop_strobe(tag, per, hi);
      q_per.delete();
      q_hi.delete();
      q_act.delete();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst    = 1'b1;
      pwm_in = 1'b0;
      tick(3);
      check("rst_period", 32'(period), 32'd0);
      check("rst_high",   32'(high_time), 32'd0);
      check("rst_valid",  32'(valid), 32'd0);
      check("rst_active", 32'(active), 32'd0);
      check("rst_stuck",  32'(stuck_level), 32'd0);
      rst = 1'b0;
      tick(2);
      check("arm_state", 32'(dut.state_q), 32'd1);
      check_strobes("arm", 0, 0, 0);

      // generator-style waveform: first rise only arms
      wave(2501, 2500, 4);
      check_strobes("gen", 3, 5001, 2501);

      // stuck high: limit reached TIMEOUT cycles after the counted rise
      pwm_in = 1'b1;
      tick(2 + TO);
      check("sh_active_before", 32'(active), 32'd1);
      check_strobes("gen4", 1, 5001, 2501);
      tick(1);
      check("sh_active", 32'(active), 32'd0);
      check("sh_stuck",  32'(stuck_level), 32'd1);
      check("sh_valid",  32'(valid), 32'd0);
      check("sh_period", 32'(period), 32'd5001);
      check("sh_high",   32'(high_time), 32'd2501);
      check("sh_state",  32'(dut.state_q), 32'd0);

      // relock on 1000/300 then stuck low
      pwm_in = 1'b0;
      tick(10);
      wave(300, 700, 2);
      pwm_in = 1'b1;
      tick(300);
      pwm_in = 1'b0;
      tick(2 + TO - 300);
      check("sl_active_before", 32'(active), 32'd1);
      tick(1);
      check("sl_active", 32'(active), 32'd0);
      check("sl_stuck",  32'(stuck_level), 32'd0);
      check("sl_period", 32'(period), 32'd1000);
      check("sl_high",   32'(high_time), 32'd300);
      check_strobes("lock2", 2, 1000, 300);

      // input high across reset release
      rst    = 1'b1;
      pwm_in = 1'b1;
      tick(3);
      check("hr_period", 32'(period), 32'd0);
      check("hr_stuck",  32'(stuck_level), 32'd0);
      rst = 1'b0;
      tick(300);
      pwm_in = 1'b0;
      tick(700);
      wave(300, 700, 1);
      pwm_in = 1'b1;
      tick(2501);
      pwm_in = 1'b0;
      check_strobes("hirst", 2, 1000, 300);

      // period change mid-stream
      tick(2500);
      pwm_in = 1'b1;
      tick(2501);
      pwm_in = 1'b0;
      tick(1000);
      wave(50, 150, 3);
      pwm_in = 1'b1;
      tick(5);
      check("chg_count", 32'(q_per.size()), 32'd5);
      pop_strobe("chg_old", 5001, 2501);
      pop_strobe("chg_mixed", 3501, 2501);
      check_strobes("chg_new", 3, 200, 50);

      // reset while in LOW
      tick(45);
      pwm_in = 1'b0;
      tick(20);
      check("rl_state_low", 32'(dut.state_q), 32'd3);
      check("rl_active_before", 32'(active), 32'd1);
      rst = 1'b1;
      tick(1);
      check("rl_valid",  32'(valid), 32'd0);
      check("rl_active", 32'(active), 32'd0);
      check("rl_period", 32'(period), 32'd0);
      check("rl_high",   32'(high_time), 32'd0);
      rst = 1'b0;
      tick(5);
      check_strobes("rl_idle", 0, 0, 0);
      pwm_in = 1'b1;
      tick(50);
      pwm_in = 1'b0;
      tick(150);
      check("rl_no_partial", 32'(q_per.size()), 32'd0);
      pwm_in = 1'b1;
      tick(5);
      check_strobes("rl_first", 1, 200, 50);

      // period exactly TIMEOUT: the edge wins over the limit
      tick(995);
      pwm_in = 1'b0;
      tick(TO - 1000);
      pwm_in = 1'b1;
      tick(5);
      check_strobes("edge_wins", 1, TO, 1000);
      check("edge_wins_active", 32'(active), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
